// File: rtl/csla_pkg.sv
// Shared definitions for datapaths built around the 64-bit carry-select adder.
// Contents:
//   CSLA_W      - adder operand width
//   CSLA_RES_W  - adder result width (sum plus carry-out)
//   MAX_ID_W    - widest requester tag any client of this package may use
//   csla_rsp_t  - registered result record {id, cout, sum}
package csla_pkg;

  localparam int CSLA_W     = 64;
  localparam int CSLA_RES_W = 65;
  localparam int MAX_ID_W   = 8;

  typedef struct packed {
    logic [MAX_ID_W-1:0] id;
    logic                cout;
    logic [CSLA_W-1:0]   sum;
  } csla_rsp_t;

endpackage

// File: rtl/SQRT_CSLA_64bit.sv
// 64-bit square-root carry-select adder.
// Ports:
//   a, b  - 64-bit operands
//   cin   - carry-in
//   sum   - a + b + cin modulo 2^64
//   cout  - carry-out of bit 63
// Blocks grow in width along the carry chain so the two precomputed block sums
// settle at roughly the same time as the select carry arriving from below.
module SQRT_CSLA_64bit (
  input  logic [63:0] a,
  input  logic [63:0] b,
  input  logic        cin,
  output logic [63:0] sum,
  output logic        cout
);

  localparam int NB = 11;
  localparam int BW  [NB] = '{2, 2, 3, 4, 5, 6, 7, 8, 9, 10, 8};
  localparam int BLO [NB] = '{0, 2, 4, 7, 11, 16, 22, 29, 37, 46, 56};

  logic [NB:0] blkCarry;

  assign blkCarry[0] = cin;

  // Each block computes its sum for both possible incoming carries, then the
  // real carry from the block below picks one of them.
  for (genvar k = 0; k < NB; k++) begin : gBlk
    localparam int LO = BLO[k];
    localparam int W  = BW[k];

    logic [W:0] sumC0;
    logic [W:0] sumC1;

    assign sumC0 = {1'b0, a[LO +: W]} + {1'b0, b[LO +: W]};
    assign sumC1 = {1'b0, a[LO +: W]} + {1'b0, b[LO +: W]} + (W+1)'(1);

    assign sum[LO +: W]    = blkCarry[k] ? sumC1[W-1:0] : sumC0[W-1:0];
    assign blkCarry[k + 1] = blkCarry[k] ? sumC1[W]     : sumC0[W];
  end

  assign cout = blkCarry[NB];

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter, reusable by any shared datapath.
// Ports:
//   req       - per-requester request bits
//   ptr       - index holding highest priority this cycle
//   grant     - one-hot grant to the first requester at or after ptr (wrapping)
//   grant_idx - binary index of the granted requester (0 when none)
//   any       - at least one request present
module rr_arbiter #(
  parameter int N   = 4,
  parameter int IDW = $clog2(N)
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  output logic [N-1:0]   grant,
  output logic [IDW-1:0] grant_idx,
  output logic           any
);

  // Walk the requesters from the farthest offset back to ptr itself so the
  // closest valid requester at or after ptr is the last one written and wins.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any       = |req;
    for (int k = N - 1; k >= 0; k--) begin
      int j;
      j = (int'(ptr) + k) % N;
      if (req[j]) begin
        grant     = '0;
        grant[j]  = 1'b1;
        grant_idx = IDW'(j);
      end
    end
  end

endmodule

// File: rtl/csla_add_arbiter.sv
// Shares one 64-bit carry-select adder among N_REQ requesters.
// Ports:
//   clk, rst             - clock and synchronous active-high reset
//   req_valid/req_ready  - per-requester handshake, at most one ready at a time
//   req_a, req_b, req_cin- packed per-requester operands (slice i = [64i+63:64i])
//   rsp_valid/rsp_ready  - result handshake toward the consumer
//   rsp_id               - requester owning the current result
//   rsp_sum, rsp_cout    - registered A+B+Cin result
module csla_add_arbiter
  import csla_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req_valid,
  output logic [N_REQ-1:0]        req_ready,
  input  logic [N_REQ*CSLA_W-1:0] req_a,
  input  logic [N_REQ*CSLA_W-1:0] req_b,
  input  logic [N_REQ-1:0]        req_cin,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [ID_W-1:0]         rsp_id,
  output logic [CSLA_W-1:0]       rsp_sum,
  output logic                    rsp_cout
);

  logic [ID_W-1:0]   ptr_q, ptr_d;
  logic              rspValid_q, rspValid_d;
  csla_rsp_t         rsp_q, rsp_d;

  logic [N_REQ-1:0]  grant;
  logic [ID_W-1:0]   grantIdx;
  logic              anyReq;
  logic              slotFree;
  logic              accept;
  logic [CSLA_W-1:0] opA, opB;
  logic              opCin;
  logic [CSLA_W-1:0] addSum;
  logic              addCout;

  rr_arbiter #(.N(N_REQ), .IDW(ID_W)) uArb (
    .req       (req_valid),
    .ptr       (ptr_q),
    .grant     (grant),
    .grant_idx (grantIdx),
    .any       (anyReq)
  );

  // The result slot can take a new value when empty or being drained this
  // cycle; ready is held low throughout reset so nothing is accepted then.
  always_comb begin
    slotFree  = !rspValid_q || rsp_ready;
    accept    = slotFree && anyReq && !rst;
    req_ready = accept ? grant : '0;
  end

  // AND-OR operand mux driven by the one-hot grant keeps the mux shallow in
  // front of the adder.
  always_comb begin
    opA   = '0;
    opB   = '0;
    opCin = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      opA   = opA | ({CSLA_W{grant[i]}} & req_a[i*CSLA_W +: CSLA_W]);
      opB   = opB | ({CSLA_W{grant[i]}} & req_b[i*CSLA_W +: CSLA_W]);
      opCin = opCin | (grant[i] & req_cin[i]);
    end
  end

  SQRT_CSLA_64bit uAdder (
    .a    (opA),
    .b    (opB),
    .cin  (opCin),
    .sum  (addSum),
    .cout (addCout)
  );

  // A new accept overwrites the slot and advances priority past the winner;
  // otherwise the slot only empties when the consumer takes it, and priority
  // stays put so idle cycles do not rotate it.
  always_comb begin
    ptr_d      = ptr_q;
    rsp_d      = rsp_q;
    rspValid_d = rspValid_q && !rsp_ready;
    if (accept) begin
      rspValid_d = 1'b1;
      rsp_d.id   = MAX_ID_W'(grantIdx);
      rsp_d.cout = addCout;
      rsp_d.sum  = addSum;
      ptr_d      = (grantIdx == ID_W'(N_REQ - 1)) ? '0 : grantIdx + ID_W'(1);
    end
  end

  // State register; reset drops any pending result without delivering it.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q      <= '0;
      rspValid_q <= 1'b0;
      rsp_q      <= '0;
    end else begin
      ptr_q      <= ptr_d;
      rspValid_q <= rspValid_d;
      rsp_q      <= rsp_d;
    end
  end

  assign rsp_valid = rspValid_q;
  assign rsp_id    = ID_W'(rsp_q.id);
  assign rsp_sum   = rsp_q.sum;
  assign rsp_cout  = rsp_q.cout;

endmodule

// File: tb/tb_csla_add_arbiter.sv
// Testbench for csla_add_arbiter with four requesters: table of single-requester
// adds, hand-written round-robin / backpressure / reset sequences, and a random
// soak against a behavioural model plus per-requester result scoreboard.
module tb_csla_add_arbiter;

  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [N*64-1:0] req_a;
  logic [N*64-1:0] req_b;
  logic [N-1:0]   req_cin;
  logic           rsp_valid;
  logic           rsp_ready;
  logic [1:0]     rsp_id;
  logic [63:0]    rsp_sum;
  logic           rsp_cout;

  int checks = 0;
  int errors = 0;

  // Per-requester operands currently presented
  logic [63:0] aOps [N];
  logic [63:0] bOps [N];
  logic        cOps [N];

  // Behavioural model of the result slot and priority pointer
  logic        mValid;
  int          mId;
  logic [64:0] mRes;
  int          mPtr;

  // Per-requester queues of results accepted but not yet delivered
  logic [64:0] sbQ [N][$];

  // req_ready as sampled in the most recent applyStimulus call
  logic [N-1:0] lastReady;

  typedef struct {
    logic [N-1:0] valid;
    logic [63:0]  a;
    logic [63:0]  b;
    logic         cin;
    logic [N-1:0] expReady;
    int           expId;
    logic [63:0]  expSum;
    logic         expCout;
  } vec_t;

  vec_t vecs [6];

  csla_add_arbiter #(.N_REQ(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_cin   (req_cin),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_sum   (rsp_sum),
    .rsp_cout  (rsp_cout)
  );

  always #5 clk = ~clk;

  // Single comparison point: every check is counted and failures reported here.
  task automatic checkOutput(input string name, input logic [64:0] actual, input logic [64:0] required);
    checks++;
    if (actual !== required) begin
      errors++;
      $display("[TB] FAIL %s actual=%h required=%h at %0t", name, actual, required, $time);
    end
  endtask

  task automatic setOps(input int i, input logic [63:0] a, input logic [63:0] b, input logic c);
    aOps[i] = a;
    bOps[i] = b;
    cOps[i] = c;
  endtask

  task automatic randomOps();
    for (int i = 0; i < N; i++) begin
      case ($urandom_range(0, 7))
        0:       setOps(i, 64'hFFFF_FFFF_FFFF_FFFF, {$urandom, $urandom}, 1'($urandom));
        1:       setOps(i, 64'h0, 64'h0, 1'($urandom));
        default: setOps(i, {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom));
      endcase
    end
  endtask

  // Drive one cycle, check the combinational ready and any delivery before the
  // edge, then advance the model and check the registered outputs after it.
  task automatic applyStimulus(input logic [N-1:0] v, input logic rr);
    int          win;
    logic        slotFree;
    logic [N-1:0] expReady;
    logic [64:0] expRes;
    req_valid = v;
    rsp_ready = rr;
    for (int i = 0; i < N; i++) begin
      req_a[i*64 +: 64] = aOps[i];
      req_b[i*64 +: 64] = bOps[i];
      req_cin[i]        = cOps[i];
    end
    #1;
    slotFree = !mValid || rr;
    win = -1;
    for (int k = 0; k < N; k++) begin
      int idx;
      idx = (mPtr + k) % N;
      if (win < 0 && v[idx]) win = idx;
    end
    expReady = '0;
    if (slotFree && win >= 0) expReady[win] = 1'b1;
    lastReady = req_ready;
    checkOutput("req_ready", 65'(req_ready), 65'(expReady));
    if (rsp_valid && rr) begin
      if (sbQ[rsp_id].size() == 0) begin
        checkOutput("sb_unexpected_result", 65'(1), 65'(0));
      end else begin
        expRes = sbQ[rsp_id].pop_front();
        checkOutput("sb_result", {rsp_cout, rsp_sum}, expRes);
      end
    end
    @(posedge clk);
    #1;
    if (slotFree && win >= 0) begin
      mValid = 1'b1;
      mId    = win;
      mRes   = {1'b0, aOps[win]} + {1'b0, bOps[win]} + 65'(cOps[win]);
      mPtr   = (win + 1) % N;
      sbQ[win].push_back(mRes);
    end else if (rr) begin
      mValid = 1'b0;
    end
    checkOutput("rsp_valid", 65'(rsp_valid), 65'(mValid));
    checkOutput("rsp_id", 65'(rsp_id), 65'(mId));
    checkOutput("rsp_sum", 65'(rsp_sum), 65'(mRes[63:0]));
    checkOutput("rsp_cout", 65'(rsp_cout), 65'(mRes[64]));
  endtask

  // One reset cycle with the given valids presented; pending results are lost.
  task automatic doReset(input logic [N-1:0] v);
    rst       = 1'b1;
    req_valid = v;
    rsp_ready = 1'b1;
    #1;
    checkOutput("reset_req_ready", 65'(req_ready), 65'(0));
    @(posedge clk);
    #1;
    checkOutput("reset_rsp_valid", 65'(rsp_valid), 65'(0));
    checkOutput("reset_rsp_id", 65'(rsp_id), 65'(0));
    checkOutput("reset_rsp_sum", 65'(rsp_sum), 65'(0));
    checkOutput("reset_rsp_cout", 65'(rsp_cout), 65'(0));
    mValid = 1'b0;
    mId    = 0;
    mRes   = '0;
    mPtr   = 0;
    for (int i = 0; i < N; i++) sbQ[i].delete();
    rst = 1'b0;
  endtask

  initial begin
    int pending;
    rst       = 1'b1;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    req_cin   = '0;
    rsp_ready = 1'b1;
    lastReady = '0;
    for (int i = 0; i < N; i++) setOps(i, 64'h0, 64'h0, 1'b0);

    vecs[0] = '{4'b0100, 64'h1, 64'h2, 1'b0, 4'b0100, 2, 64'h3, 1'b0};
    vecs[1] = '{4'b0010, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 4'b0010, 1, 64'h0, 1'b1};
    vecs[2] = '{4'b1000, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 4'b1000, 3,
                64'hFFFF_FFFF_FFFF_FFFF, 1'b1};
    vecs[3] = '{4'b0001, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 4'b0001, 0,
                64'h0, 1'b1};
    vecs[4] = '{4'b0100, 64'h0123_4567_89AB_CDEF, 64'h1111_1111_1111_1111, 1'b0, 4'b0100, 2,
                64'h1234_5678_9ABC_DF00, 1'b0};
    vecs[5] = '{4'b0001, 64'h5, 64'h7, 1'b1, 4'b0001, 0, 64'hD, 1'b0};

    doReset('0);

    // Single-requester table
    for (int t = 0; t < 6; t++) begin
      for (int i = 0; i < N; i++) setOps(i, vecs[t].a, vecs[t].b, vecs[t].cin);
      applyStimulus(vecs[t].valid, 1'b1);
      checkOutput("tbl_ready", 65'(lastReady), 65'(vecs[t].expReady));
      checkOutput("tbl_valid", 65'(rsp_valid), 65'(1));
      checkOutput("tbl_id", 65'(rsp_id), 65'(vecs[t].expId));
      checkOutput("tbl_sum", 65'(rsp_sum), 65'(vecs[t].expSum));
      checkOutput("tbl_cout", 65'(rsp_cout), 65'(vecs[t].expCout));
    end

    // Round-robin from reset with all requesters valid
    doReset('0);
    for (int c = 0; c < 8; c++) begin
      randomOps();
      applyStimulus(4'hF, 1'b1);
      checkOutput("rr_valid", 65'(rsp_valid), 65'(1));
      checkOutput("rr_id", 65'(rsp_id), 65'(c % N));
    end

    // Backpressure: result from requester 0 held for three cycles
    doReset('0);
    for (int i = 0; i < N; i++) setOps(i, 64'd100, 64'd20, 1'b0);
    applyStimulus(4'hF, 1'b1);
    for (int c = 0; c < 3; c++) begin
      applyStimulus(4'hF, 1'b0);
      checkOutput("bp_ready", 65'(lastReady), 65'(0));
      checkOutput("bp_valid", 65'(rsp_valid), 65'(1));
      checkOutput("bp_id", 65'(rsp_id), 65'(0));
      checkOutput("bp_sum", 65'(rsp_sum), 65'(120));
    end
    applyStimulus(4'hF, 1'b1);
    checkOutput("bp_release_ready", 65'(lastReady), 65'(4'b0010));
    checkOutput("bp_release_id", 65'(rsp_id), 65'(1));

    // Reset while a result is pending, then lowest valid index wins
    checkOutput("mid_pending", 65'(rsp_valid), 65'(1));
    doReset(4'b1100);
    applyStimulus(4'b1100, 1'b1);
    checkOutput("mid_first_ready", 65'(lastReady), 65'(4'b0100));
    checkOutput("mid_first_id", 65'(rsp_id), 65'(2));

    // Random soak
    for (int c = 0; c < 20000; c++) begin
      randomOps();
      applyStimulus(4'($urandom), ($urandom_range(0, 3) != 0));
    end

    // Drain and confirm nothing was lost
    applyStimulus('0, 1'b1);
    applyStimulus('0, 1'b1);
    pending = 0;
    for (int i = 0; i < N; i++) pending += sbQ[i].size();
    checkOutput("sb_lost_results", 65'(pending), 65'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
